// File: rtl/vc_pop_arbiter_pkg.sv
// Shared types and defaults for the VC pop arbiter.
// State encodings double as the arb_state debug output values.
package vc_pop_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_SERV0 = 2'd1,
    ARB_SERV1 = 2'd2,
    ARB_HOLD  = 2'd3
  } arb_state_t;

  localparam int unsigned DEF_MAX_VC0_BURST = 4;
  localparam int unsigned DEF_CNT_W         = 3;

  function automatic logic is_serving(input arb_state_t s);
    return (s == ARB_SERV0) || (s == ARB_SERV1);
  endfunction

endpackage

// File: rtl/vc_pop_arbiter_burst_cnt.sv
// Saturating count of consecutive VC0 grants while VC1 is waiting.
// guard_force asks the arbiter to serve VC1 once the limit is reached.
module vc_arb_burst_cnt #(
  parameter int unsigned MAX_VC0_BURST = 4,
  parameter int unsigned CNT_W         = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic grant_vc0,
  input  logic grant_vc1,
  input  logic vc1_empty,
  output logic guard_force
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_VC0_BURST);

  logic [CNT_W-1:0] burst_cnt;

  // Clear on VC1 service or when VC1 has nothing queued; otherwise count VC0 grants up to the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if (grant_vc1 || vc1_empty) begin
      burst_cnt <= '0;
    end else if (grant_vc0 && (burst_cnt != LIMIT)) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  assign guard_force = (burst_cnt == LIMIT);

endmodule

// File: rtl/vc_pop_arbiter.sv
// VC0/VC1 pop arbiter: strict VC0 priority, pause stalls all pops,
// selector/valid_out registered to line up with the FIFO 1-cycle read latency.
// Optional starvation guard enabled by defining VC_ARB_STARVE_GUARD_EN.
module vc_pop_arbiter
  import vc_pop_arbiter_pkg::*;
#(
  parameter int unsigned MAX_VC0_BURST = DEF_MAX_VC0_BURST,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       vc0_empty,
  input  logic       vc1_empty,
  input  logic       pause,
  output logic       pop_VC0,
  output logic       pop_VC1,
  output logic       selector,
  output logic       valid_out,
  output logic [1:0] arb_state
);

  arb_state_t state, next;
  logic       guard_force;

  if (CNT_W < $clog2(MAX_VC0_BURST + 1)) begin : g_width_check
    $error("CNT_W too narrow for MAX_VC0_BURST");
  end

`ifdef VC_ARB_STARVE_GUARD_EN
  vc_arb_burst_cnt #(
    .MAX_VC0_BURST (MAX_VC0_BURST),
    .CNT_W         (CNT_W)
  ) u_burst_cnt (
    .clk         (clk),
    .rst_n       (reset_L),
    .grant_vc0   (pop_VC0),
    .grant_vc1   (pop_VC1),
    .vc1_empty   (vc1_empty),
    .guard_force (guard_force)
  );
`else
  assign guard_force = 1'b0;
`endif

  // Grant decision in priority order; pops are masked while reset is asserted.
  always_comb begin
    pop_VC0 = 1'b0;
    pop_VC1 = 1'b0;
    next    = ARB_IDLE;
    if (pause) begin
      next = ARB_HOLD;
    end else if (guard_force && !vc1_empty) begin
      pop_VC1 = 1'b1;
      next    = ARB_SERV1;
    end else if (!vc0_empty) begin
      pop_VC0 = 1'b1;
      next    = ARB_SERV0;
    end else if (!vc1_empty) begin
      pop_VC1 = 1'b1;
      next    = ARB_SERV1;
    end
    if (!reset_L) begin
      pop_VC0 = 1'b0;
      pop_VC1 = 1'b0;
    end
  end

  // State and mux-side outputs; selector keeps its last value when nothing was popped.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= ARB_IDLE;
      selector  <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      state     <= next;
      valid_out <= is_serving(next);
      if (is_serving(next)) begin
        selector <= (next == ARB_SERV1);
      end
    end
  end

  assign arb_state = state;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Directed-vector bench with an expectation queue and a negedge monitor.
module tb_vc_pop_arbiter;

  typedef struct packed {
    logic       pop0;
    logic       pop1;
    logic       sel;
    logic       valid;
    logic [1:0] state;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       vc0_empty = 1'b0;
  logic       vc1_empty = 1'b0;
  logic       pause = 1'b0;
  logic       pop_VC0, pop_VC1, selector, valid_out;
  logic [1:0] arb_state;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   vec_no = 0;

  always #5 clk = ~clk;

  vc_pop_arbiter #(
    .MAX_VC0_BURST (4),
    .CNT_W         (3)
  ) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .vc0_empty (vc0_empty),
    .vc1_empty (vc1_empty),
    .pause     (pause),
    .pop_VC0   (pop_VC0),
    .pop_VC1   (pop_VC1),
    .selector  (selector),
    .valid_out (valid_out),
    .arb_state (arb_state)
  );

  // One cycle: drive inputs just after the rising edge and queue what the monitor must see this cycle.
  task automatic v(input logic rst, input logic e0, input logic e1, input logic p,
                   input logic ep0, input logic ep1, input logic es, input logic ev,
                   input logic [1:0] est);
    exp_t e;
    @(posedge clk);
    #1;
    reset_L   = rst;
    vc0_empty = e0;
    vc1_empty = e1;
    pause     = p;
    e.pop0  = ep0;
    e.pop1  = ep1;
    e.sel   = es;
    e.valid = ev;
    e.state = est;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle with an outstanding expectation, compare all outputs at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a = '{pop0: pop_VC0, pop1: pop_VC1, sel: selector, valid: valid_out, state: arb_state};
      vec_no++;
      checks++;
      if (a === e) passes++;
      else $display("FAIL vec%0d: got pop0=%b pop1=%b sel=%b valid=%b state=%0d, want pop0=%b pop1=%b sel=%b valid=%b state=%0d",
                    vec_no, a.pop0, a.pop1, a.sel, a.valid, a.state,
                    e.pop0, e.pop1, e.sel, e.valid, e.state);
    end
  end

  initial begin
    //    rst e0 e1 p   pop0 pop1 sel val st
    // T1 reset with both FIFOs non-empty, then release
    v(0, 0, 0, 0,   0, 0, 0, 0, 0);
    v(0, 0, 0, 0,   0, 0, 0, 0, 0);
    v(1, 0, 0, 0,   1, 0, 0, 0, 0);
    // T2 priority streaming VC0
    v(1, 0, 0, 0,   1, 0, 0, 1, 1);
    v(1, 0, 0, 0,   1, 0, 0, 1, 1);
    v(1, 1, 1, 0,   0, 0, 0, 1, 1);
    v(1, 1, 1, 0,   0, 0, 0, 0, 0);
    // T3 VC1 only; selector holds through IDLE
    v(1, 1, 0, 0,   0, 1, 0, 0, 0);
    v(1, 1, 1, 0,   0, 0, 1, 1, 2);
    v(1, 1, 1, 0,   0, 0, 1, 0, 0);
    // T4 pause mid-stream
    v(1, 0, 1, 0,   1, 0, 1, 0, 0);
    v(1, 0, 1, 0,   1, 0, 0, 1, 1);
    v(1, 0, 1, 1,   0, 0, 0, 1, 1);
    v(1, 0, 1, 1,   0, 0, 0, 0, 3);
    v(1, 0, 1, 0,   1, 0, 0, 0, 3);
    v(1, 1, 1, 0,   0, 0, 0, 1, 1);
    // pause beats both non-empty; VC1 back-to-back; VC0 pre-empts
    v(1, 0, 0, 1,   0, 0, 0, 0, 0);
    v(1, 1, 0, 0,   0, 1, 0, 0, 3);
    v(1, 1, 0, 0,   0, 1, 1, 1, 2);
    v(1, 0, 0, 0,   1, 0, 1, 1, 2);
    v(1, 1, 1, 1,   0, 0, 0, 1, 1);
    v(1, 1, 0, 1,   0, 0, 0, 0, 3);
    v(1, 1, 0, 0,   0, 1, 0, 0, 3);
    v(1, 1, 1, 0,   0, 0, 1, 1, 2);
    v(1, 1, 1, 0,   0, 0, 1, 0, 0);
    // T5 both non-empty for six cycles
`ifdef VC_ARB_STARVE_GUARD_EN
    v(1, 0, 0, 0,   1, 0, 1, 0, 0);
    v(1, 0, 0, 0,   1, 0, 0, 1, 1);
    v(1, 0, 0, 0,   1, 0, 0, 1, 1);
    v(1, 0, 0, 0,   1, 0, 0, 1, 1);
    v(1, 0, 0, 0,   0, 1, 0, 1, 1);
    v(1, 0, 0, 0,   1, 0, 1, 1, 2);
`else
    v(1, 0, 0, 0,   1, 0, 1, 0, 0);
    v(1, 0, 0, 0,   1, 0, 0, 1, 1);
    v(1, 0, 0, 0,   1, 0, 0, 1, 1);
    v(1, 0, 0, 0,   1, 0, 0, 1, 1);
    v(1, 0, 0, 0,   1, 0, 0, 1, 1);
    v(1, 0, 0, 0,   1, 0, 0, 1, 1);
`endif
    v(1, 1, 1, 0,   0, 0, 0, 1, 1);
    // T6 async reset between edges while streaming
    v(1, 0, 0, 0,   1, 0, 0, 0, 0);
    v(1, 0, 0, 0,   1, 0, 0, 1, 1);
    v(0, 0, 0, 0,   0, 0, 0, 0, 0);
    v(1, 1, 0, 0,   0, 1, 0, 0, 0);
    v(1, 1, 1, 0,   0, 0, 1, 1, 2);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
